// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// FIFO entry layout and PC alignment helpers.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRY_W = 2 * XLEN;

  localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with a single-cycle flush; DEPTH must be a
// power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is nonzero.
  always_ff @(posedge clock_i) begin
    if (!reset_i && !flush_i && do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// word requests to instruction memory and streams {pc, inst} to the core.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  logic [1:0]   state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         req_q, req_d;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;
  logic         fifo_empty;
  logic         fifo_full;
  logic [CW-1:0] fifo_count;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata_i};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Next-state, PC update and FIFO control; redirect outranks everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    fifo_pop   = !fifo_empty && inst_ready_i;

    if (redirect_i) begin
      fifo_flush = 1'b1;
      fifo_pop   = 1'b0;
      fetch_pc_d = align_pc(redirect_pc_i);
      case (state_q)
        S_REQ:     state_d = imem_ack_i ? S_REQ : S_DISCARD;
        S_DISCARD: state_d = imem_ack_i ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_full) state_d = S_REQ;
        end
        S_REQ: begin
          if (imem_ack_i) begin
            fifo_push  = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            // count is below depth here, so one push fills it only without a pop
            if (fifo_pop || (fifo_count < CW'(FIFO_DEPTH - 1))) begin
              state_d = S_REQ;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (imem_ack_i) state_d = S_REQ;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The stale request keeps its address until its ack drains it.
    addr_d = (state_d == S_DISCARD) ? addr_q : fetch_pc_d;
    req_d  = (state_d == S_REQ) || (state_d == S_DISCARD);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC_ALIGNED;
      addr_q     <= RESET_PC_ALIGNED;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? NOP_INST : head_entry.inst;
  assign inst_pc_o    = fifo_empty ? 32'h0000_0000 : head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects during
// slow memory, address wrap-around and reset in the middle of a fetch.
module tb_fetch_unit;

  logic        clock;
  logic        reset, reset2;
  logic        ack, ack2;
  logic [31:0] rdata, rdata2;
  logic        ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req, req2;
  logic [31:0] addr, addr2;
  logic        valid, valid2;
  logic [31:0] inst, inst2;
  logic [31:0] pc, pc2;
  logic        ready2;
  logic        redirect2;
  logic [31:0] redirect_pc2;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ack_i   (ack),
    .imem_rdata_i (rdata),
    .inst_valid_o (valid),
    .inst_o       (inst),
    .inst_pc_o    (pc),
    .inst_ready_i (ready),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_wrap (
    .clock_i      (clock),
    .reset_i      (reset2),
    .imem_req_o   (req2),
    .imem_addr_o  (addr2),
    .imem_ack_i   (ack2),
    .imem_rdata_i (rdata2),
    .inst_valid_o (valid2),
    .inst_o       (inst2),
    .inst_pc_o    (pc2),
    .inst_ready_i (ready2),
    .redirect_i   (redirect2),
    .redirect_pc_i(redirect_pc2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Zero-wait memory: acknowledge whatever is being requested right now.
  task automatic zw();
    ack   = req;
    rdata = dfun(addr);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    ack      = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   32'(req),   32'd0);
    chk({tag, "_addr"},  addr,       32'h0000_0000);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_inst"},  inst,       32'h0000_0013);
    chk({tag, "_pc"},    pc,         32'h0000_0000);
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    ack = 1'b0; ack2 = 1'b0; rdata = '0; rdata2 = '0;
    ready = 1'b0; ready2 = 1'b1;
    redirect = 1'b0; redirect_pc = '0;
    redirect2 = 1'b0; redirect_pc2 = '0;

    // Reset values, then streaming with zero-wait memory and an eager core.
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_addr", addr, 32'(4 * i));
      chk("stream_req", 32'(req), 32'd1);
      if (i > 0) begin
        chk("stream_valid", 32'(valid), 32'd1);
        chk("stream_pc", pc, 32'(4 * (i - 1)));
        chk("stream_inst", inst, dfun(32'(4 * (i - 1))));
      end else begin
        chk("stream_valid0", 32'(valid), 32'd0);
      end
      zw();
    end

    // Back-pressure: two acks fill the FIFO, then requests stop.
    do_reset();
    ready = 1'b0;
    tick(); chk("bp_addr0", addr, 32'h0); zw();
    tick(); chk("bp_addr1", addr, 32'h4); chk("bp_pc0", pc, 32'h0); zw();
    tick(); chk("bp_req_off", 32'(req), 32'd0); chk("bp_head", pc, 32'h0); zw();
    tick(); chk("bp_req_off2", 32'(req), 32'd0); chk("bp_valid", 32'(valid), 32'd1); zw();
    ready = 1'b1;
    tick(); chk("bp_req_off3", 32'(req), 32'd0); chk("bp_pop4", pc, 32'h4);
    chk("bp_inst4", inst, dfun(32'h4)); zw();
    tick(); chk("bp_resume_req", 32'(req), 32'd1); chk("bp_resume_addr", addr, 32'h8);
    chk("bp_empty", 32'(valid), 32'd0);
    ready = 1'b0; zw();

    // Slow memory with a redirect while the request to 0x8 is pending.
    do_reset();
    ready = 1'b1;
    tick(); chk("slow_a0", addr, 32'h0); zw();
    tick(); chk("slow_a4", addr, 32'h4); zw();
    tick(); chk("slow_a8", addr, 32'h8); ack = 1'b0;
    tick(); chk("slow_hold1", addr, 32'h8); chk("slow_empty", 32'(valid), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick(); chk("slow_hold2", addr, 32'h8); chk("slow_req", 32'(req), 32'd1);
    chk("slow_novalid", 32'(valid), 32'd0);
    redirect = 1'b0; ack = 1'b1; rdata = 32'hDEAD_BEEF;
    tick(); chk("slow_newaddr", addr, 32'h100); chk("slow_dropped", 32'(valid), 32'd0); zw();
    tick(); chk("slow_pc100", pc, 32'h100); chk("slow_inst100", inst, dfun(32'h100));
    ack = 1'b0; ready = 1'b0;

    // Redirect to an unaligned target coincident with an ack and a pop.
    do_reset();
    ready = 1'b1;
    tick(); chk("rd_a0", addr, 32'h0); zw();
    tick(); chk("rd_pc0", pc, 32'h0); zw();
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick(); chk("rd_flushed", 32'(valid), 32'd0); chk("rd_addr", addr, 32'h200);
    chk("rd_req", 32'(req), 32'd1);
    redirect = 1'b0; zw();
    tick(); chk("rd_valid", 32'(valid), 32'd1); chk("rd_pc200", pc, 32'h200);
    chk("rd_inst200", inst, dfun(32'h200));
    ack = 1'b0; ready = 1'b0;

    // Wrap-around from a reset PC near the top of the address space.
    chk("wrap_rst_addr", addr2, 32'hFFFF_FFF8);
    chk("wrap_rst_req", 32'(req2), 32'd0);
    reset2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      tick();
      e = 32'hFFFF_FFF8 + 32'(4 * i);
      chk("wrap_addr", addr2, e);
      if (i > 0) chk("wrap_pc", pc2, e - 32'd4);
      ack2   = req2;
      rdata2 = dfun(addr2);
    end
    ack2 = 1'b0;

    // Reset while discarding a stale request; the late ack must be ignored.
    do_reset();
    ready = 1'b0;
    tick(); chk("rdis_a0", addr, 32'h0); ack = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_0040;
    tick(); chk("rdis_hold", addr, 32'h0); chk("rdis_req", 32'(req), 32'd1);
    redirect = 1'b0; reset = 1'b1; ack = 1'b1; rdata = 32'h0BAD_0BAD;
    tick(); chk_reset_vals("rdis");
    reset = 1'b0; ack = 1'b0;
    tick(); chk("rdis_restart", addr, 32'h0); chk("rdis_restart_req", 32'(req), 32'd1);
    chk("rdis_novalid", 32'(valid), 32'd0); zw();
    tick(); chk("rdis_pc0", pc, 32'h0); chk("rdis_inst0", inst, dfun(32'h0));

    // Reset with one buffered entry and a request still waiting for its ack.
    do_reset();
    ready = 1'b0;
    tick(); zw();
    tick(); chk("rent_pc0", pc, 32'h0); ack = 1'b0;
    tick(); chk("rent_valid", 32'(valid), 32'd1); chk("rent_addr4", addr, 32'h4);
    reset = 1'b1; ack = 1'b1; rdata = 32'h0BAD_0BAD;
    tick(); chk_reset_vals("rent");
    reset = 1'b0; ack = 1'b0;
    tick(); chk("rent_restart", addr, 32'h0); chk("rent_req", 32'(req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
